// File: rtl/div_issue_ctrl_pkg.sv
// Shared definitions for the EXE-stage divider issue controller.
// State encoding and divider timing constants.
package div_issue_ctrl_pkg;

    localparam int WIDTH = 32;

    // Launch edge to the cycle in which the divider raises complete_i.
    localparam int DIV_LAUNCH_TO_COMPLETE = 33;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_issue_ctrl.sv
// Requester-side controller for the non-abortable iterative divider:
// launches DIV/DIVU, stalls EXE until done, drains cancelled divides, writes HI/LO.
module div_issue_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             div_clk,
    input  logic             resetn,
    input  logic             req_valid,
    input  logic             req_signed,
    input  logic [WIDTH-1:0] req_x,
    input  logic [WIDTH-1:0] req_y,
    input  logic             cancel,
    output logic             div_o,
    output logic             div_signed_o,
    output logic [WIDTH-1:0] x_o,
    output logic [WIDTH-1:0] y_o,
    output logic             choke_o,
    input  logic [WIDTH-1:0] s_i,
    input  logic [WIDTH-1:0] r_i,
    input  logic             complete_i,
    output logic             stall_o,
    output logic             busy,
    output logic             hilo_we,
    output logic [WIDTH-1:0] hi_wdata,
    output logic [WIDTH-1:0] lo_wdata
);
    import div_issue_ctrl_pkg::*;

    div_state_e state_q;
    div_state_e state_d;
    logic       div_d;
    logic       hilo_we_d;
    logic       latch_req;
    logic       latch_res;

    assign choke_o = 1'b0;

    always_comb begin
        state_d   = state_q;
        div_d     = div_o;
        hilo_we_d = 1'b0;
        latch_req = 1'b0;
        latch_res = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid && !cancel) begin
                    state_d   = S_BUSY;
                    div_d     = 1'b1;
                    latch_req = 1'b1;
                end
            end
            S_BUSY: begin
                if (complete_i) begin
                    div_d = 1'b0;
                    if (cancel) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DONE;
                        latch_res = 1'b1;
                        hilo_we_d = 1'b1;
                    end
                end else if (cancel) begin
                    state_d = S_DRAIN;
                end
            end
            // The divider cannot be aborted: keep div_o high until it finishes.
            S_DRAIN: begin
                if (complete_i) begin
                    div_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                div_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                div_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Released in DONE so the instruction retires without relaunching.
    assign stall_o = ((state_q == S_IDLE) && req_valid && !cancel) ||
                     (state_q == S_BUSY) ||
                     ((state_q == S_DRAIN) && req_valid);

    always_ff @(posedge div_clk) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            div_o        <= 1'b0;
            div_signed_o <= 1'b0;
            x_o          <= '0;
            y_o          <= '0;
            hilo_we      <= 1'b0;
            busy         <= 1'b0;
            hi_wdata     <= '0;
            lo_wdata     <= '0;
        end else begin
            state_q <= state_d;
            div_o   <= div_d;
            hilo_we <= hilo_we_d;
            busy    <= (state_d != S_IDLE);
            if (latch_req) begin
                div_signed_o <= req_signed;
                x_o          <= req_x;
                y_o          <= req_y;
            end
            if (latch_res) begin
                lo_wdata <= s_i;
                hi_wdata <= r_i;
            end
        end
    end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a fixed-latency divider model beside it.
module tb_div_issue_ctrl;

    logic        div_clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic        req_signed;
    logic [31:0] req_x;
    logic [31:0] req_y;
    logic        cancel;
    logic        div_o;
    logic        div_signed_o;
    logic [31:0] x_o;
    logic [31:0] y_o;
    logic        choke_o;
    logic [31:0] s_i;
    logic [31:0] r_i;
    logic        complete_i;
    logic        stall_o;
    logic        busy;
    logic        hilo_we;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;

    int total = 0;
    int bad   = 0;
    int cnt   = 0;
    int viol  = 0;

    always #5 div_clk = ~div_clk;

    div_issue_ctrl #(.WIDTH(32)) dut (
        .div_clk      (div_clk),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .req_signed   (req_signed),
        .req_x        (req_x),
        .req_y        (req_y),
        .cancel       (cancel),
        .div_o        (div_o),
        .div_signed_o (div_signed_o),
        .x_o          (x_o),
        .y_o          (y_o),
        .choke_o      (choke_o),
        .s_i          (s_i),
        .r_i          (r_i),
        .complete_i   (complete_i),
        .stall_o      (stall_o),
        .busy         (busy),
        .hilo_we      (hilo_we),
        .hi_wdata     (hi_wdata),
        .lo_wdata     (lo_wdata)
    );

    function automatic logic [63:0] ref_div(input logic sg, input logic [31:0] x, input logic [31:0] y);
        if (y == 32'h0) return {32'hFFFFFFFF, x};
        if (sg) begin
            if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h80000000, 32'h0};
            return {32'($signed(x) / $signed(y)), 32'($signed(x) % $signed(y))};
        end
        return {x / y, x % y};
    endfunction

    // Divider model: complete_i pulses after div_o has been high for the fixed latency.
    always @(posedge div_clk) begin
        if (!resetn) begin
            cnt        <= 0;
            complete_i <= 1'b0;
            s_i        <= '0;
            r_i        <= '0;
        end else if (complete_i) begin
            complete_i <= 1'b0;
            cnt        <= 0;
        end else if (div_o) begin
            if (cnt == div_issue_ctrl_pkg::DIV_LAUNCH_TO_COMPLETE - 1) begin
                complete_i <= 1'b1;
                {s_i, r_i} <= ref_div(div_signed_o, x_o, y_o);
            end
            cnt <= cnt + 1;
        end else begin
            if (cnt != 0) viol <= viol + 1;
            cnt <= 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge div_clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_div"}, 32'(div_o), 0);
        chk({tag, "_sgn"}, 32'(div_signed_o), 0);
        chk({tag, "_we"}, 32'(hilo_we), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_x"}, x_o, 0);
        chk({tag, "_y"}, y_o, 0);
        chk({tag, "_hi"}, hi_wdata, 0);
        chk({tag, "_lo"}, lo_wdata, 0);
        chk({tag, "_choke"}, 32'(choke_o), 0);
        chk({tag, "_stall"}, 32'(stall_o), 0);
    endtask

    // Called at edge+1 of the request's cycle 0; returns at edge+2 of the hilo_we cycle.
    task automatic run_div(input logic sg, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] elo, input logic [31:0] ehi, input string tag);
        int stalls = 0;
        int c_cyc = -1;
        int w_cyc = -1;
        int d_first = -1;
        int sg_bad = 0;
        logic [31:0] lo = '0;
        logic [31:0] hi = '0;
        req_signed = sg;
        req_x      = x;
        req_y      = y;
        req_valid  = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            #1;
            if (stall_o) stalls++;
            if (complete_i && c_cyc < 0) c_cyc = cyc;
            if (div_o && d_first < 0) d_first = cyc;
            if (div_o && div_signed_o !== sg) sg_bad++;
            if (hilo_we) begin
                w_cyc = cyc;
                lo    = lo_wdata;
                hi    = hi_wdata;
            end
            if (w_cyc >= 0) break;
            tick();
        end
        chk({tag, "_launch"}, d_first, 1);
        chk({tag, "_cplcyc"}, c_cyc, 34);
        chk({tag, "_wecyc"}, w_cyc, 35);
        chk({tag, "_stalls"}, stalls, 35);
        chk({tag, "_sgn"}, sg_bad, 0);
        chk({tag, "_lo"}, lo, elo);
        chk({tag, "_hi"}, hi, ehi);
    endtask

    task automatic drop_and_check(input string tag);
        tick();
        req_valid = 1'b0;
        #1;
        chk({tag, "_norelaunch"}, 32'(div_o), 0);
        chk({tag, "_idle"}, 32'(busy), 0);
    endtask

    initial begin
        int dcnt;
        int hw;
        int c_cyc;
        resetn     = 1'b0;
        req_valid  = 1'b0;
        req_signed = 1'b0;
        req_x      = '0;
        req_y      = '0;
        cancel     = 1'b0;
        repeat (3) @(posedge div_clk);
        #2;
        check_reset("rst");
        tick();
        resetn = 1'b1;

        tick();
        run_div(1'b1, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 32'hFFFFFFFF, "sdiv");
        drop_and_check("sdiv");

        tick();
        run_div(1'b0, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 32'h0000000F, "udiv");
        drop_and_check("udiv");

        // Cancel in cycle 10, then a new instruction arrives while draining.
        tick();
        req_signed = 1'b0;
        req_x      = 32'd100;
        req_y      = 32'd7;
        req_valid  = 1'b1;
        dcnt  = 0;
        hw    = 0;
        c_cyc = -1;
        for (int cyc = 0; cyc < 35; cyc++) begin
            if (cyc == 10) cancel = 1'b1;
            if (cyc == 11) begin
                cancel    = 1'b0;
                req_valid = 1'b0;
            end
            if (cyc == 15) begin
                req_valid = 1'b1;
                req_x     = 32'd50;
                req_y     = 32'd5;
            end
            #1;
            if (div_o) dcnt++;
            if (hilo_we) hw++;
            if (complete_i && c_cyc < 0) c_cyc = cyc;
            if (cyc == 11) chk("drain_busy", 32'(busy), 1);
            if (cyc == 15) chk("drain_stall", 32'(stall_o), 1);
            if (cyc == 34) chk("drain_x_held", x_o, 32'd100);
            tick();
        end
        chk("drain_divhigh", dcnt, 34);
        chk("drain_nowe", hw, 0);
        chk("drain_cpl", c_cyc, 34);
        run_div(1'b0, 32'd50, 32'd5, 32'd10, 32'd0, "after_drain");
        drop_and_check("after_drain");

        // Cancel coincident with complete_i.
        tick();
        req_signed = 1'b1;
        req_x      = 32'd100;
        req_y      = 32'd7;
        req_valid  = 1'b1;
        hw = 0;
        for (int cyc = 0; cyc < 37; cyc++) begin
            if (cyc == 34) cancel = 1'b1;
            if (cyc == 35) begin
                cancel    = 1'b0;
                req_valid = 1'b0;
            end
            #1;
            if (hilo_we) hw++;
            if (cyc == 34) chk("cc_cpl", 32'(complete_i), 1);
            if (cyc == 35) begin
                chk("cc_div", 32'(div_o), 0);
                chk("cc_idle", 32'(busy), 0);
            end
            tick();
        end
        chk("cc_nowe", hw, 0);
        chk("cc_lo_kept", lo_wdata, 32'd10);

        // Back-to-back: second request presented in the cycle after DONE.
        run_div(1'b1, 32'd100, 32'd7, 32'd14, 32'd2, "b2b1");
        tick();
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, "b2b2");
        drop_and_check("b2b2");

        // Reset asserted in cycle 20 of a divide.
        tick();
        req_signed = 1'b0;
        req_x      = 32'd100;
        req_y      = 32'd7;
        req_valid  = 1'b1;
        repeat (20) tick();
        resetn    = 1'b0;
        req_valid = 1'b0;
        tick();
        resetn = 1'b1;
        #1;
        check_reset("midrst");
        tick();
        run_div(1'b1, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 32'hFFFFFFFF, "post_rst");
        drop_and_check("post_rst");

        chk("proto_div_drop", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
Requester-side controller for the iterative 32-bit divider, sitting in the EXE stage between decoded DIV/DIVU instructions and the HI/LO register file. It launches a division, holds operands and the request stable for the whole operation, and stalls the pipeline until the result is ready. It handles pipeline cancellation (exception or flush) by draining the in-flight divide, because the divider cannot be aborted, then discarding the result. It writes the quotient to LO and the remainder to HI.

Parameters:
WIDTH, 32, operand width; 32 is the only legal value, fixed by the divider.

Ports:
div_clk  in  1  clock
resetn  in  1  synchronous active-low reset
req_valid  in  1  EXE holds a DIV/DIVU; held high until stall_o is sampled low
req_signed  in  1  1 = DIV, 0 = DIVU
req_x  in  32  dividend
req_y  in  32  divisor
cancel  in  1  flush of the EXE instruction; one-cycle pulse
div_o  out  1  divider request
div_signed_o  out  1  to divider
x_o  out  32  to divider
y_o  out  32  to divider
choke_o  out  1  to divider; tied 0
s_i  in  32  divider quotient
r_i  in  32  divider remainder
complete_i  in  1  divider result valid; one-cycle pulse
stall_o  out  1  freeze EXE and earlier stages
busy  out  1  state != IDLE
hilo_we  out  1  one-cycle HI/LO write strobe
hi_wdata  out  32  remainder
lo_wdata  out  32  quotient

Behaviour:
- Reset and clock: resetn synchronous, active-low; clock div_clk.
- Reset values: state IDLE; div_o, div_signed_o, hilo_we and busy 0; x_o, y_o, hi_wdata and lo_wdata 0. choke_o is constant 0.
- All outputs are registered except stall_o, which is combinational from state and req_valid.
- Divider protocol:
  - div_o must stay high from launch until the cycle complete_i is sampled.
  - x_o, y_o and div_signed_o must stay stable for that whole interval.
  - div_o must drop in the cycle after complete_i. Holding it longer restarts the divider.
  - Dropping div_o mid-operation corrupts divider state. Never do it, including on cancel.
- States: IDLE, BUSY, DRAIN, DONE.
- IDLE:
  - On req_valid & !cancel: latch req_x, req_y and req_signed into x_o, y_o and div_signed_o; set div_o=1; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - div_o=1.
  - complete_i & !cancel: latch s_i into lo_wdata and r_i into hi_wdata; hilo_we=1 next cycle; div_o=0; go to DONE.
  - complete_i & cancel: div_o=0; no write; go to IDLE.
  - cancel without complete_i: go to DRAIN.
- DRAIN:
  - div_o=1; ignore req_valid.
  - On complete_i: div_o=0; discard the result; go to IDLE.
- DONE:
  - hilo_we high for exactly this cycle; div_o=0.
  - Go to IDLE unconditionally. The same instruction's req_valid still high here must not relaunch.
- stall_o = (IDLE & req_valid & !cancel) | BUSY | (DRAIN & req_valid). It is 0 in DONE, so the instruction retires.
- Latency, with the accept edge at the end of cycle 0:
  - div_o high from cycle 1.
  - complete_i arrives in cycle 34.
  - hilo_we is high in cycle 35.
  - stall_o is high in cycles 0–34 (35 cycles).
- Back-to-back: the earliest next launch is the edge ending the cycle after DONE, with div_o high again 2 cycles after hilo_we.
- Divide by zero: no special case. The divider runs normally and its result is written as produced (architecturally undefined).
- Reset mid-operation: all state returns to reset values; the divider is reset by the same resetn.
- complete_i seen in IDLE or DONE: ignored.

Decomposition:
- Shared package:
  - state encoding constants S_IDLE, S_BUSY, S_DRAIN, S_DONE (2 bits);
  - DIV_LAUNCH_TO_COMPLETE = 33;
  - WIDTH = 32.
- No sub-module. The divider is instantiated beside this block at the EXE-stage top level, with complete_i, s_i and r_i wired directly.

Test Plan:
- Signed x=0xFFFFFFF9 (-7), y=2 -> complete_i in cycle 34; hilo_we in cycle 35; lo_wdata=0xFFFFFFFD; hi_wdata=0xFFFFFFFF; stall_o high for exactly 35 cycles.
- Unsigned x=0xFFFFFFFF, y=0x10 -> lo_wdata=0x0FFFFFFF, hi_wdata=0x0000000F; div_signed_o=0 throughout.
- Cancel pulse in cycle 10 of a divide -> DRAIN; div_o stays high until complete_i; no hilo_we; a new req_valid during DRAIN sees stall_o=1 and launches only after returning to IDLE.
- cancel coincident with complete_i -> no hilo_we; div_o=0 the next cycle; state IDLE.
- Back-to-back: 100/7 then 0x80000000/0xFFFFFFFF signed -> first write lo=14, hi=2; second launch exactly 2 cycles after the first hilo_we; second write lo=0x80000000, hi=0.
- resetn low in cycle 20 of a divide -> the next cycle shows all outputs at reset values and IDLE; a fresh request completes correctly with the standard latency.
